pulse_generator: RTL and testbench

Trigger-to-pulse generator: each accepted single-cycle trigger strobe produces one output pulse with a programmable delay and width. It is the counterpart of the edge detector in the trigger path. The edge detector turns levels into strobes; this block turns strobes back into timed levels. Typical uses are a detected edge firing a gate, strobe or reset pulse of defined duration.

---
 rtl/pulse_generator.sv | 107 ++++++++++
 tb/tb_pulse_generator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Trigger-to-pulse generator: each accepted trigger strobe yields one pulse
// of programmable delay and width, with abort and drop reporting.
module pulse_generator #(
    parameter int       DELAY_W    = 16,
    parameter int       WIDTH_W    = 16,
    parameter logic     IDLE_LEVEL = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_trig,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic [WIDTH_W-1:0] i_width,
    input  logic               i_abort,
    output logic               o_out,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_drop
);

    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH_W-1:0] width_q;

    // Outputs are assigned alongside the state they decode from, so they stay registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            width_q <= '0;
            o_out   <= IDLE_LEVEL;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_trig) begin
                        if ((i_width != '0) && !i_abort) begin
                            width_q <= i_width;
                            o_busy  <= 1'b1;
                            if (i_delay == '0) begin
                                state <= S_ACTIVE;
                                cnt   <= CNT_W'(i_width) - CNT_W'(1);
                                o_out <= ~IDLE_LEVEL;
                            end else begin
                                state <= S_DELAY;
                                cnt   <= CNT_W'(i_delay) - CNT_W'(1);
                            end
                        end else begin
                            o_drop <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (i_trig) begin
                        o_drop <= 1'b1;
                    end
                    if (i_abort) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_out  <= IDLE_LEVEL;
                    end else if (cnt == '0) begin
                        state <= S_ACTIVE;
                        cnt   <= CNT_W'(width_q) - CNT_W'(1);
                        o_out <= ~IDLE_LEVEL;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (i_trig) begin
                        o_drop <= 1'b1;
                    end
                    // An abort ends the pulse silently; only a natural end reports done.
                    if (i_abort) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_out  <= IDLE_LEVEL;
                    end else if (cnt == '0) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_out  <= IDLE_LEVEL;
                        o_done <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    o_out  <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: an interval-based pulse model checked every cycle,
// plus literal expectations at hand-picked cycles for both idle levels.
module tb_pulse_generator;

    logic        clk;
    logic        i_rst;
    logic        i_trig;
    logic        i_abort;
    logic [15:0] i_delay;
    logic [15:0] i_width;
    logic        out_lo, busy_lo, done_lo, drop_lo;
    logic        out_hi, busy_hi, done_hi, drop_hi;

    int checks = 0;
    int errors = 0;

    pulse_generator #(.DELAY_W(16), .WIDTH_W(16), .IDLE_LEVEL(1'b0)) u_dut_lo (
        .i_clk(clk), .i_rst(i_rst), .i_trig(i_trig), .i_delay(i_delay),
        .i_width(i_width), .i_abort(i_abort),
        .o_out(out_lo), .o_busy(busy_lo), .o_done(done_lo), .o_drop(drop_lo)
    );

    pulse_generator #(.DELAY_W(16), .WIDTH_W(16), .IDLE_LEVEL(1'b1)) u_dut_hi (
        .i_clk(clk), .i_rst(i_rst), .i_trig(i_trig), .i_delay(i_delay),
        .i_width(i_width), .i_abort(i_abort),
        .o_out(out_hi), .o_busy(busy_hi), .o_done(done_hi), .o_drop(drop_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the running pulse is an interval [start+1, start+D+W] of busy cycles.
    longint cyc = 0;
    bit     have = 0;
    longint p_start = 0, p_d = 0, p_w = 0;
    bit     chk_en = 0;
    bit     exp_busy = 0, exp_act = 0, exp_done = 0, exp_drop = 0;
    bit     m_bz, m_nd, m_ndr;

    function automatic bit in_busy(longint c);
        return have && (c >= p_start + 1) && (c <= p_start + p_d + p_w);
    endfunction

    function automatic bit in_act(longint c);
        return have && (c >= p_start + p_d + 1) && (c <= p_start + p_d + p_w);
    endfunction

    always @(posedge clk) begin
        m_bz  = in_busy(cyc);
        m_nd  = 1'b0;
        m_ndr = 1'b0;
        if (i_rst) begin
            have   = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (m_bz && (cyc == p_start + p_d + p_w) && !i_abort) m_nd = 1'b1;
            if (m_bz && i_abort) have = 1'b0;
            if (i_trig) begin
                if (!m_bz && (i_width != 16'd0) && !i_abort) begin
                    have    = 1'b1;
                    p_start = cyc;
                    p_d     = longint'(i_delay);
                    p_w     = longint'(i_width);
                end else begin
                    m_ndr = 1'b1;
                end
            end
        end
        cyc      = cyc + 1;
        exp_busy = in_busy(cyc);
        exp_act  = in_act(cyc);
        exp_done = m_nd;
        exp_drop = m_ndr;
    end

    // History of observed outputs per cycle: {drop, done, busy, out_hi, out_lo}.
    logic [4:0] hist [longint];

    task automatic cmp(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %b required %b", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        hist[cyc] = {drop_lo, done_lo, busy_lo, out_hi, out_lo};
        if (chk_en) begin
            cmp("model_out_lo",  out_lo,  exp_act);
            cmp("model_out_hi",  out_hi,  ~exp_act);
            cmp("model_busy_lo", busy_lo, exp_busy);
            cmp("model_busy_hi", busy_hi, exp_busy);
            cmp("model_done_lo", done_lo, exp_done);
            cmp("model_done_hi", done_hi, exp_done);
            cmp("model_drop_lo", drop_lo, exp_drop);
            cmp("model_drop_hi", drop_hi, exp_drop);
        end
    end

    localparam int SEL_OUT_LO = 0;
    localparam int SEL_OUT_HI = 1;
    localparam int SEL_BUSY   = 2;
    localparam int SEL_DONE   = 3;
    localparam int SEL_DROP   = 4;

    task automatic checkOutput(input string name, input int sel, input longint c, input logic expv);
        logic [4:0] h;
        checks++;
        if (!hist.exists(c)) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual none required %b", name, c, expv);
        end else begin
            h = hist[c];
            if (h[sel] !== expv) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d actual %b required %b", name, c, h[sel], expv);
            end
        end
    endtask

    task automatic checkSpan(input string name, input int sel, input longint first,
                             input longint last, input logic expv);
        for (longint c = first; c <= last; c++) checkOutput(name, sel, c, expv);
    endtask

    task automatic applyStimulus(input bit trig, input bit abort, input bit rst,
                                 input logic [15:0] d, input logic [15:0] w);
        i_trig  = trig;
        i_abort = abort;
        i_rst   = rst;
        i_delay = d;
        i_width = w;
        @(posedge clk);
        #1;
        i_trig  = 1'b0;
        i_abort = 1'b0;
        i_rst   = 1'b0;
        i_delay = 16'($urandom);
        i_width = 16'($urandom);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    longint t;

    initial begin
        i_trig  = 1'b0;
        i_abort = 1'b0;
        i_rst   = 1'b1;
        i_delay = 16'd0;
        i_width = 16'd0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        idleCycles(2);
        checkOutput("reset_out_lo", SEL_OUT_LO, cyc - 1, 1'b0);
        checkOutput("reset_out_hi", SEL_OUT_HI, cyc - 1, 1'b1);
        checkOutput("reset_busy",   SEL_BUSY,   cyc - 1, 1'b0);
        checkOutput("reset_done",   SEL_DONE,   cyc - 1, 1'b0);
        checkOutput("reset_drop",   SEL_DROP,   cyc - 1, 1'b0);

        // D=3 W=4
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd3, 16'd4);
        idleCycles(12);
        checkOutput("d3w4_busy_pre", SEL_BUSY, t, 1'b0);
        checkSpan("d3w4_busy", SEL_BUSY, t + 1, t + 7, 1'b1);
        checkOutput("d3w4_busy_end", SEL_BUSY, t + 8, 1'b0);
        checkSpan("d3w4_out_delay", SEL_OUT_LO, t + 1, t + 3, 1'b0);
        checkSpan("d3w4_out", SEL_OUT_LO, t + 4, t + 7, 1'b1);
        checkOutput("d3w4_out_end", SEL_OUT_LO, t + 8, 1'b0);
        checkOutput("d3w4_done_early", SEL_DONE, t + 7, 1'b0);
        checkOutput("d3w4_done", SEL_DONE, t + 8, 1'b1);
        checkOutput("d3w4_done_late", SEL_DONE, t + 9, 1'b0);
        checkSpan("d3w4_drop", SEL_DROP, t + 1, t + 9, 1'b0);

        // D=0 W=1 twice, two cycles apart
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd1);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd1);
        idleCycles(4);
        checkOutput("d0w1_out_a", SEL_OUT_LO, t + 1, 1'b1);
        checkOutput("d0w1_gap",   SEL_OUT_LO, t + 2, 1'b0);
        checkOutput("d0w1_out_b", SEL_OUT_LO, t + 3, 1'b1);
        checkOutput("d0w1_done_a", SEL_DONE, t + 2, 1'b1);
        checkOutput("d0w1_done_b", SEL_DONE, t + 4, 1'b1);
        checkSpan("d0w1_drop", SEL_DROP, t + 1, t + 5, 1'b0);

        // D=2 W=5 with a second trigger mid-pulse
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd2, 16'd5);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd1);
        idleCycles(6);
        checkOutput("retrig_drop", SEL_DROP, t + 5, 1'b1);
        checkOutput("retrig_out_pre", SEL_OUT_LO, t + 2, 1'b0);
        checkSpan("retrig_out", SEL_OUT_LO, t + 3, t + 7, 1'b1);
        checkOutput("retrig_out_end", SEL_OUT_LO, t + 8, 1'b0);
        checkOutput("retrig_done", SEL_DONE, t + 8, 1'b1);

        // W=0 trigger, then abort-with-trigger in idle
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd2, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd2, 16'd3);
        idleCycles(3);
        checkOutput("w0_drop", SEL_DROP, t + 1, 1'b1);
        checkOutput("idle_abort_drop", SEL_DROP, t + 2, 1'b1);
        checkSpan("w0_busy", SEL_BUSY, t + 1, t + 3, 1'b0);
        checkSpan("w0_out",  SEL_OUT_LO, t + 1, t + 3, 1'b0);
        checkSpan("w0_done", SEL_DONE, t + 1, t + 3, 1'b0);

        // Trigger in last active cycle: done and drop together, then back-to-back
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd2);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd2);
        idleCycles(4);
        checkOutput("both_done", SEL_DONE, t + 3, 1'b1);
        checkOutput("both_drop", SEL_DROP, t + 3, 1'b1);
        checkOutput("b2b_gap", SEL_OUT_LO, t + 3, 1'b0);
        checkSpan("b2b_out", SEL_OUT_LO, t + 4, t + 5, 1'b1);
        checkOutput("b2b_done", SEL_DONE, t + 6, 1'b1);

        // Abort in active phase, with a trigger in the same cycle
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1, 16'd10);
        idleCycles(4);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 16'd3);
        idleCycles(12);
        checkSpan("abort_out", SEL_OUT_LO, t + 2, t + 5, 1'b1);
        checkSpan("abort_out_low", SEL_OUT_LO, t + 6, t + 14, 1'b0);
        checkSpan("abort_busy_low", SEL_BUSY, t + 6, t + 14, 1'b0);
        checkSpan("abort_no_done", SEL_DONE, t + 6, t + 14, 1'b0);
        checkOutput("abort_trig_drop", SEL_DROP, t + 6, 1'b1);

        // Same run ended by reset, trigger during reset ignored
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1, 16'd10);
        idleCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd0, 16'd3);
        idleCycles(12);
        checkSpan("rst_out", SEL_OUT_LO, t + 2, t + 5, 1'b1);
        checkSpan("rst_out_low", SEL_OUT_LO, t + 6, t + 14, 1'b0);
        checkSpan("rst_busy_low", SEL_BUSY, t + 6, t + 14, 1'b0);
        checkSpan("rst_no_done", SEL_DONE, t + 6, t + 14, 1'b0);
        checkOutput("rst_no_drop", SEL_DROP, t + 6, 1'b0);

        // Inverted idle level: D=0 W=2
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd2);
        idleCycles(4);
        checkOutput("hi_out_pre", SEL_OUT_HI, t, 1'b1);
        checkSpan("hi_out_active", SEL_OUT_HI, t + 1, t + 2, 1'b0);
        checkOutput("hi_out_after", SEL_OUT_HI, t + 3, 1'b1);

        // Trigger together with reset while idle
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd0, 16'd2);
        idleCycles(3);
        checkSpan("trig_rst_out_hi", SEL_OUT_HI, t + 1, t + 2, 1'b1);
        checkSpan("trig_rst_busy", SEL_BUSY, t + 1, t + 2, 1'b0);
        checkOutput("trig_rst_drop", SEL_DROP, t + 1, 1'b0);

        // Directed mixed pattern exercised against the model only
        for (int i = 0; i < 120; i++) begin
            applyStimulus((i % 3) == 0, (i % 17) == 9, (i % 53) == 40,
                          16'(i % 4), 16'(i % 5));
        end
        idleCycles(10);

        // Maximum delay: D=0xFFFF W=1 starts 65536 cycles after the trigger
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        idleCycles(100);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 16'd5);
        idleCycles(65440);
        checkOutput("max_busy_first", SEL_BUSY, t + 1, 1'b1);
        checkOutput("max_busy_last", SEL_BUSY, t + 65536, 1'b1);
        checkOutput("max_mid_drop", SEL_DROP, t + 102, 1'b1);
        checkOutput("max_out_pre", SEL_OUT_LO, t + 65535, 1'b0);
        checkOutput("max_out", SEL_OUT_LO, t + 65536, 1'b1);
        checkOutput("max_out_post", SEL_OUT_LO, t + 65537, 1'b0);
        checkOutput("max_done", SEL_DONE, t + 65537, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
